// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter and next-PC selector.
// Resolves the ID-stage branch/jump (single delay slot, never squashed),
// holds the PC on hazard stalls and traps misaligned jr/jalr targets.
// Optional feature macro: BRANCH_STATS_EN enables the branch counters;
// when it is undefined br_total_o and br_taken_o are tied to zero.
module pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic [3:0]  br_type_i,
   input  logic        equal_i,
   input  logic        gez_i,
   input  logic        lez_i,
   input  logic [31:0] pc_id_i,
   input  logic [15:0] imm16_i,
   input  logic [25:0] index26_i,
   input  logic [31:0] rs_val_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] npc_o,
   output logic        taken_o,
   output logic [31:0] link_o,
   output logic        adel_o,
   output logic [31:0] br_total_o,
   output logic [31:0] br_taken_o
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HOLD = 2'd1,
      ST_TRAP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_id_plus4_s;
   logic [31:0] br_off_s;
   logic [31:0] target_s;
   logic        taken_s;
   logic        is_jr_s;
   logic        misalign_s;

   assign pc_id_plus4_s = pc_id_i + 32'd4;
   assign br_off_s      = {{14{imm16_i[15]}}, imm16_i, 2'b00};
   assign is_jr_s       = (br_type_i == 4'd9) || (br_type_i == 4'd10);
   assign misalign_s    = taken_s && is_jr_s && (rs_val_i[1:0] != 2'b00);

   // Decode the comparator flags into the ID-stage taken decision.
   always_comb begin
      taken_s = 1'b0;
      case (br_type_i)
         4'd1:    taken_s = equal_i;
         4'd2:    taken_s = ~equal_i;
         4'd3:    taken_s = gez_i;
         4'd4:    taken_s = lez_i;
         4'd5:    taken_s = gez_i & ~lez_i;
         4'd6:    taken_s = ~gez_i;
         4'd7,
         4'd8,
         4'd9,
         4'd10:   taken_s = 1'b1;
         default: taken_s = 1'b0;
      endcase
   end

   // Select the control-transfer target for the instruction in ID.
   always_comb begin
      target_s = pc_id_plus4_s + br_off_s;
      case (br_type_i)
         4'd7,
         4'd8:    target_s = {pc_id_plus4_s[31:28], index26_i, 2'b00};
         4'd9,
         4'd10:   target_s = rs_val_i;
         default: target_s = pc_id_plus4_s + br_off_s;
      endcase
   end

   assign taken_o    = taken_s;
   assign pc_plus4_o = pc_q + 32'd4;
   assign npc_o      = taken_s ? target_s : (pc_q + 32'd4);
   assign link_o     = pc_id_i + 32'd8;
   assign pc_o       = pc_q;
   assign adel_o     = (state_q == ST_TRAP);

   // Next-state and next-PC selection; stall outranks every redirect.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         ST_RUN,
         ST_HOLD: begin
            if (stall_i) begin
               state_d = ST_HOLD;
               pc_d    = pc_q;
            end else if (misalign_s) begin
               state_d = ST_TRAP;
               pc_d    = EXC_PC;
            end else begin
               state_d = ST_RUN;
               pc_d    = npc_o;
            end
         end
         ST_TRAP: begin
            if (stall_i) begin
               state_d = ST_HOLD;
               pc_d    = pc_q;
            end else begin
               state_d = ST_RUN;
               pc_d    = EXC_PC + 32'd4;
            end
         end
         default: begin
            state_d = ST_RUN;
            pc_d    = RESET_PC;
         end
      endcase
   end

   // State and PC registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] br_total_q, br_total_d;
   logic [31:0] br_taken_q, br_taken_d;
   logic        is_branch_s;

   assign is_branch_s = (br_type_i >= 4'd1) && (br_type_i <= 4'd6);

   // Count conditional branches (and the taken ones) on non-stalled edges.
   always_comb begin
      br_total_d = br_total_q;
      br_taken_d = br_taken_q;
      if (!stall_i && is_branch_s) begin
         br_total_d = br_total_q + 32'd1;
         if (taken_s) begin
            br_taken_d = br_taken_q + 32'd1;
         end else begin
            br_taken_d = br_taken_q;
         end
      end else begin
         br_total_d = br_total_q;
         br_taken_d = br_taken_q;
      end
   end

   // Branch statistics registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         br_total_q <= 32'd0;
         br_taken_q <= 32'd0;
      end else begin
         br_total_q <= br_total_d;
         br_taken_q <= br_taken_d;
      end
   end

   assign br_total_o = br_total_q;
   assign br_taken_o = br_taken_q;
`else
   assign br_total_o = 32'd0;
   assign br_taken_o = 32'd0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed test-plan cases with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_pc_unit;
   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC    = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic [3:0]  br_type;
   logic        equal, gez, lez;
   logic [31:0] pc_id;
   logic [15:0] imm16;
   logic [25:0] index26;
   logic [31:0] rs_val;
   logic [31:0] pc, pc_plus4, npc, link, br_total, br_taken;
   logic        taken, adel;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   logic [31:0] m_pc;
   bit          m_trap;
   logic [31:0] m_tot, m_tk;

   pc_unit dut (
      .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .br_type_i(br_type),
      .equal_i(equal), .gez_i(gez), .lez_i(lez), .pc_id_i(pc_id),
      .imm16_i(imm16), .index26_i(index26), .rs_val_i(rs_val),
      .pc_o(pc), .pc_plus4_o(pc_plus4), .npc_o(npc), .taken_o(taken),
      .link_o(link), .adel_o(adel), .br_total_o(br_total), .br_taken_o(br_taken)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_taken();
      case (br_type)
         4'd1: return equal;
         4'd2: return !equal;
         4'd3: return gez;
         4'd4: return lez;
         4'd5: return gez && !lez;
         4'd6: return !gez;
         4'd7, 4'd8, 4'd9, 4'd10: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_target();
      int off;
      off = int'($signed(imm16)) * 4;
      if (br_type == 4'd7 || br_type == 4'd8)
         return ((pc_id + 32'd4) & 32'hF000_0000) | ({6'd0, index26} * 32'd4);
      if (br_type == 4'd9 || br_type == 4'd10)
         return rs_val;
      return pc_id + 32'd4 + 32'(off);
   endfunction

   function automatic logic [31:0] m_npc();
      return m_taken() ? m_target() : m_pc + 32'd4;
   endfunction

   task automatic drive(input bit st, input logic [3:0] bt, input bit eq, input bit ge,
                        input bit le, input logic [31:0] pid, input logic [15:0] im,
                        input logic [25:0] idx, input logic [31:0] rs);
      stall = st; br_type = bt; equal = eq; gez = ge; lez = le;
      pc_id = pid; imm16 = im; index26 = idx; rs_val = rs;
   endtask

   // compare every output against the model, away from the active edge
   task automatic check_cycle();
      @(negedge clk);
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("taken", {31'd0, taken}, {31'd0, m_taken()});
      chk("npc", npc, m_npc());
      chk("link", link, pc_id + 32'd8);
      chk("adel", {31'd0, adel}, {31'd0, m_trap});
`ifdef BRANCH_STATS_EN
      chk("br_total", br_total, m_tot);
      chk("br_taken", br_taken, m_tk);
`else
      chk("br_total", br_total, 32'd0);
      chk("br_taken", br_taken, 32'd0);
`endif
   endtask

   // advance one edge and update the model from the current inputs
   task automatic adv();
      logic [31:0] n_pc;
      bit          n_trap;
      bit          jr_bad;
      jr_bad = m_taken() && (br_type == 4'd9 || br_type == 4'd10) && (rs_val[1:0] != 2'b00);
      n_trap = 1'b0;
      if (stall)        n_pc = m_pc;
      else if (m_trap)  n_pc = EXC + 32'd4;
      else if (jr_bad) begin n_pc = EXC; n_trap = 1'b1; end
      else              n_pc = m_npc();
      if (!stall && br_type >= 4'd1 && br_type <= 4'd6) begin
         m_tot = m_tot + 32'd1;
         if (m_taken()) m_tk = m_tk + 32'd1;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc;
      m_trap = n_trap;
   endtask

   task automatic step();
      check_cycle();
      adv();
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_trap = 1'b0; m_tot = 32'd0; m_tk = 32'd0;
   endtask

   logic [31:0] held_pc, tot0, tk0;

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      chk("rst_pc", pc, 32'h0000_3000);
      chk("rst_adel", {31'd0, adel}, 32'd0);
      chk("rst_tot", br_total, 32'd0);
      chk("rst_tk", br_taken, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      m_pc = 32'h0000_3004;  // first edge after release loads RESET_PC + 4
      chk("first_edge", pc, 32'h0000_3004);
      step(); chk("seq2", pc, 32'h0000_3008);
      step(); chk("seq3", pc, 32'h0000_300C);

      // beq taken backwards by one word
      drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0000_3004, 16'hFFFF, 26'h0, 32'h0);
      check_cycle();
      chk("beq_taken", {31'd0, taken}, 32'd1);
      chk("beq_npc", npc, 32'h0000_3004);
      adv();
      chk("beq_pc", pc, 32'h0000_3004);
      equal = 1'b0;
      check_cycle();
      chk("beq_nt_taken", {31'd0, taken}, 32'd0);
      chk("beq_nt_npc", npc, 32'h0000_3008);
      adv();

      // bgtz
      drive(1'b0, 4'd5, 1'b0, 1'b1, 1'b1, 32'h0000_3100, 16'h0002, 26'h0, 32'h0);
      check_cycle();
      chk("bgtz_nt", {31'd0, taken}, 32'd0);
      adv();
      lez = 1'b0;
      check_cycle();
      chk("bgtz_t", {31'd0, taken}, 32'd1);
      chk("bgtz_npc", npc, 32'h0000_310C);
      adv();

      // jal held by stall for two edges
      drive(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 32'h0000_3010, 16'h0, 26'h0000C40, 32'h0);
      held_pc = pc;
      step(); step();
      chk("stall_hold", pc, held_pc);
      stall = 1'b0;
      check_cycle();
      chk("jal_link", link, 32'h0000_3018);
      chk("jal_npc", npc, 32'h0000_3100);
      adv();
      chk("jal_pc", pc, 32'h0000_3100);

      // misaligned jr: stalled first, then trapped
      drive(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 32'h0000_3100, 16'h0, 26'h0, 32'h0000_3002);
      step();
      chk("jr_stall_noadel", {31'd0, adel}, 32'd0);
      chk("jr_stall_pc", pc, 32'h0000_3100);
      stall = 1'b0;
      step();
      chk("trap_adel", {31'd0, adel}, 32'd1);
      chk("trap_pc", pc, 32'h0000_4180);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      step();
      chk("trap_next", pc, 32'h0000_4184);
      chk("trap_pulse", {31'd0, adel}, 32'd0);

      // pc wrap
      drive(1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
      step();
      chk("wrap_pre", pc, 32'hFFFF_FFFC);
      br_type = 4'd0;
      check_cycle();
      chk("wrap_plus4", pc_plus4, 32'h0000_0000);
      adv();
      chk("wrap_pc", pc, 32'h0000_0000);

      // five branches, three taken, one taken branch issued under stall
      tot0 = br_total; tk0 = br_taken;
      drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 32'h100, 16'h4, 26'h0, 32'h0); step(); // taken
      drive(1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 32'h100, 16'h4, 26'h0, 32'h0); step(); // not
      drive(1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 32'h100, 16'h4, 26'h0, 32'h0); step(); // stalled
      drive(1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 32'h100, 16'h4, 26'h0, 32'h0); step(); // taken
      drive(1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 32'h100, 16'h4, 26'h0, 32'h0); step(); // not
`ifdef BRANCH_STATS_EN
      chk("stat_total", br_total - tot0, 32'd4);
      chk("stat_taken", br_taken - tk0, 32'd2);
`else
      chk("stat_total_off", br_total, 32'd0);
      chk("stat_taken_off", br_taken, 32'd0);
`endif

      // randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
               1'($urandom), 1'($urandom), 1'($urandom), $urandom,
               16'($urandom), 26'($urandom),
               ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom);
         step();
      end

      // reset asserted while in TRAP
      drive(1'b0, 4'd10, 1'b0, 1'b0, 1'b0, 32'h200, 16'h0, 26'h0, 32'h0000_5001);
      step();
      chk("pre_rst_adel", {31'd0, adel}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_adel", {31'd0, adel}, 32'd0);
      chk("async_rst_pc", pc, 32'h0000_3000);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      @(posedge clk); #1;
      chk("rst_stall_pc", pc, 32'h0000_3000);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // global time bound so the run always terminates
   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end
endmodule
